// File: rtl/key_cfg_ctrl.sv
// rtl/key_cfg_ctrl.sv - key-driven brightness/contrast register write controller
module key_cfg_ctrl #(
    parameter int         KEY_W       = 4,
    parameter logic [7:0] BRIGHT_ADDR = 8'h55,
    parameter logic [7:0] CONTR_ADDR  = 8'h56,
    parameter logic [7:0] STEP        = 8'h10,
    parameter logic [7:0] BRIGHT_INIT = 8'h00,
    parameter logic [7:0] CONTR_INIT  = 8'h40,
    parameter int         TIMEOUT     = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_vld,
    input  logic             cfg_en,
    output logic             wr_en,
    output logic [7:0]       wr_addr,
    output logic [7:0]       wr_data,
    input  logic             wr_rdy,
    input  logic             wr_done,
    output logic [7:0]       bright,
    output logic [7:0]       contrast,
    output logic             busy,
    output logic             err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [KEY_W-1:0] pending_q;
    logic [KEY_W-1:0] grant_oh;
    logic [KEY_W-1:0] clr_mask;
    logic [CNT_W-1:0] cnt_q;

    logic       key_b;
    logic       key_c;
    logic       key_plus;
    logic [7:0] old_val;
    logic [7:0] new_val;
    logic [8:0] sum9;
    logic [8:0] diff9;
    logic       load_req;
    logic       upd_b;
    logic       upd_c;
    logic       set_err;
    logic       cnt_clr;
    logic       cnt_inc;

    // Lowest-index pending bit wins; the decode only covers the four defined keys,
    // extra key lines are consumed without touching a setting.
    always_comb begin
        grant_oh = pending_q & (~pending_q + KEY_W'(1));
        key_b    = grant_oh[0] | grant_oh[1];
        key_c    = grant_oh[2] | grant_oh[3];
        key_plus = grant_oh[0] | grant_oh[2];
        old_val  = key_c ? contrast : bright;
        sum9     = {1'b0, old_val} + {1'b0, STEP};
        diff9    = {1'b0, old_val} - {1'b0, STEP};
        if (!(key_b || key_c)) begin
            new_val = old_val;
        end else if (key_plus) begin
            new_val = sum9[8] ? 8'hFF : sum9[7:0];
        end else begin
            new_val = diff9[8] ? 8'h00 : diff9[7:0];
        end
    end

    // Next-state and per-cycle control strobes for the transaction FSM.
    always_comb begin
        state_d  = state_q;
        clr_mask = '0;
        load_req = 1'b0;
        upd_b    = 1'b0;
        upd_c    = 1'b0;
        set_err  = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_en && (pending_q != '0)) begin
                    clr_mask = grant_oh;
                    if (new_val != old_val) begin
                        load_req = 1'b1;
                        upd_b    = key_b;
                        upd_c    = key_c;
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                if (wr_en && wr_rdy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wr_done) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    set_err = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending key latch; a new press beats the clear of the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_mask) | key_vld;
        end
    end

    // State register with the registered busy flag tracking the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
        end
    end

    // Settings, write request, timeout counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            wr_addr  <= 8'h00;
            wr_data  <= 8'h00;
            bright   <= BRIGHT_INIT;
            contrast <= CONTR_INIT;
            err      <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wr_en <= (state_d == REQ);
            if (load_req) begin
                wr_addr <= upd_c ? CONTR_ADDR : BRIGHT_ADDR;
                wr_data <= new_val;
            end
            if (upd_b) begin
                bright <= new_val;
            end
            if (upd_c) begin
                contrast <= new_val;
            end
            if (set_err) begin
                err <= 1'b1;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_key_cfg_ctrl.sv
// tb/tb_key_cfg_ctrl.sv - directed self-checking bench for key_cfg_ctrl
module tb_key_cfg_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_vld;
    logic       cfg_en;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_rdy;
    logic       wr_done;
    logic [7:0] bright;
    logic [7:0] contrast;
    logic       busy;
    logic       err;

    int checks;
    int errors;

    key_cfg_ctrl #(
        .KEY_W      (4),
        .BRIGHT_ADDR(8'h55),
        .CONTR_ADDR (8'h56),
        .STEP       (8'h10),
        .BRIGHT_INIT(8'h00),
        .CONTR_INIT (8'h40),
        .TIMEOUT    (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_vld (key_vld),
        .cfg_en  (cfg_en),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_rdy  (wr_rdy),
        .wr_done (wr_done),
        .bright  (bright),
        .contrast(contrast),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] m);
        key_vld = m;
        tick();
        key_vld = 4'b0000;
    endtask

    task automatic pulse_done();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if ({wr_en, wr_addr, wr_data} !== 17'h0) begin errors++; $display("FAIL reset_wr: got %h exp 00000", {wr_en, wr_addr, wr_data}); end
        checks++; if ({bright, contrast} !== 16'h0040) begin errors++; $display("FAIL reset_settings: got %h exp 0040", {bright, contrast}); end
        checks++; if ({busy, err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b exp 00", {busy, err}); end
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if ({wr_en, busy} !== 2'b00) begin errors++; $display("FAIL reset_idle: got %b exp 00", {wr_en, busy}); end
    endtask

    task automatic test_basic();
        press(4'b0001);
        tick();
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL basic_wr_en: got %b exp 1", wr_en); end
        checks++; if (wr_addr !== 8'h55) begin errors++; $display("FAIL basic_addr: got %h exp 55", wr_addr); end
        checks++; if (wr_data !== 8'h10) begin errors++; $display("FAIL basic_data: got %h exp 10", wr_data); end
        checks++; if (bright !== 8'h10) begin errors++; $display("FAIL basic_bright: got %h exp 10", bright); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b exp 1", busy); end
        tick();
        checks++; if ({wr_en, busy} !== 2'b01) begin errors++; $display("FAIL basic_wait: got %b exp 01", {wr_en, busy}); end
        repeat (4) tick();
        pulse_done();
        checks++; if ({wr_en, busy} !== 2'b00) begin errors++; $display("FAIL basic_done: got %b exp 00", {wr_en, busy}); end
    endtask

    task automatic test_saturate();
        logic [8:0] exp_v;
        press(4'b0010);
        tick();
        checks++; if ({wr_en, wr_data} !== 9'h100) begin errors++; $display("FAIL sat_dec_to_zero: got %h exp 100", {wr_en, wr_data}); end
        tick();
        pulse_done();
        press(4'b0010);
        tick();
        checks++; if ({wr_en, busy, bright} !== 10'h000) begin errors++; $display("FAIL sat_floor_nowrite: got %h exp 000", {wr_en, busy, bright}); end
        tick();
        checks++; if ({wr_en, busy} !== 2'b00) begin errors++; $display("FAIL sat_floor_cleared: got %b exp 00", {wr_en, busy}); end
        for (int k = 1; k <= 17; k++) begin
            exp_v = (k * 16 > 255) ? 9'h0FF : 9'(k * 16);
            press(4'b0001);
            tick();
            if (k <= 16) begin
                checks++; if ({wr_en, wr_data, bright} !== {1'b1, exp_v[7:0], exp_v[7:0]}) begin errors++; $display("FAIL sat_inc_%0d: got %h exp %h", k, {wr_en, wr_data, bright}, {1'b1, exp_v[7:0], exp_v[7:0]}); end
                tick();
                pulse_done();
            end else begin
                checks++; if ({wr_en, busy, bright} !== 10'h0FF) begin errors++; $display("FAIL sat_ceiling_nowrite: got %h exp 0ff", {wr_en, busy, bright}); end
            end
        end
    endtask

    task automatic test_multi();
        do_reset();
        press(4'b1001);
        tick();
        checks++; if ({wr_en, wr_addr, wr_data} !== 17'h15510) begin errors++; $display("FAIL multi_first: got %h exp 15510", {wr_en, wr_addr, wr_data}); end
        tick();
        pulse_done();
        tick();
        checks++; if ({wr_en, wr_addr, wr_data} !== 17'h15630) begin errors++; $display("FAIL multi_second: got %h exp 15630", {wr_en, wr_addr, wr_data}); end
        checks++; if ({bright, contrast} !== 16'h1030) begin errors++; $display("FAIL multi_settings: got %h exp 1030", {bright, contrast}); end
        tick();
        pulse_done();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multi_idle: got %b exp 0", busy); end
    endtask

    task automatic test_rdy_stall();
        wr_rdy = 1'b0;
        press(4'b0100);
        tick();
        checks++; if ({wr_en, wr_addr, wr_data} !== 17'h15640) begin errors++; $display("FAIL stall_start: got %h exp 15640", {wr_en, wr_addr, wr_data}); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if ({busy, wr_en, wr_addr, wr_data} !== 18'h35640) begin errors++; $display("FAIL stall_hold_%0d: got %h exp 35640", i, {busy, wr_en, wr_addr, wr_data}); end
        end
        wr_rdy = 1'b1;
        tick();
        checks++; if ({wr_en, busy} !== 2'b01) begin errors++; $display("FAIL stall_to_wait: got %b exp 01", {wr_en, busy}); end
        pulse_done();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_done: got %b exp 0", busy); end
    endtask

    task automatic test_cfg_gate();
        cfg_en = 1'b0;
        press(4'b0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({wr_en, busy} !== 2'b00) begin errors++; $display("FAIL gate_hold_%0d: got %b exp 00", i, {wr_en, busy}); end
        end
        cfg_en = 1'b1;
        tick();
        checks++; if ({wr_en, wr_addr, wr_data} !== 17'h15520) begin errors++; $display("FAIL gate_release: got %h exp 15520", {wr_en, wr_addr, wr_data}); end
        tick();
        pulse_done();
    endtask

    task automatic test_timeout();
        press(4'b0011);
        tick();
        checks++; if ({wr_en, wr_data} !== 9'h130) begin errors++; $display("FAIL to_req: got %h exp 130", {wr_en, wr_data}); end
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++; if ({err, busy} !== 2'b01) begin errors++; $display("FAIL to_waiting_%0d: got %b exp 01", i, {err, busy}); end
        end
        tick();
        checks++; if ({err, busy, bright} !== 10'h230) begin errors++; $display("FAIL to_expired: got %h exp 230", {err, busy, bright}); end
        tick();
        checks++; if ({wr_en, wr_addr, wr_data} !== 17'h15520) begin errors++; $display("FAIL to_next_key: got %h exp 15520", {wr_en, wr_addr, wr_data}); end
        tick();
        pulse_done();
        checks++; if ({err, busy, bright} !== 10'h220) begin errors++; $display("FAIL to_sticky: got %h exp 220", {err, busy, bright}); end
    endtask

    task automatic test_reset_wait();
        press(4'b0100);
        tick();
        tick();
        tick();
        checks++; if ({wr_en, busy, contrast} !== 10'h150) begin errors++; $display("FAIL rw_in_wait: got %h exp 150", {wr_en, busy, contrast}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({wr_en, wr_addr, wr_data} !== 17'h0) begin errors++; $display("FAIL rw_async_wr: got %h exp 00000", {wr_en, wr_addr, wr_data}); end
        checks++; if ({bright, contrast, busy, err} !== 18'h00100) begin errors++; $display("FAIL rw_async_state: got %h exp 00100", {bright, contrast, busy, err}); end
        tick();
        tick();
        rst_n = 1'b1;
        pulse_done();
        checks++; if ({wr_en, busy} !== 2'b00) begin errors++; $display("FAIL rw_stale_done: got %b exp 00", {wr_en, busy}); end
        tick();
        checks++; if ({wr_en, busy} !== 2'b00) begin errors++; $display("FAIL rw_stale_idle: got %b exp 00", {wr_en, busy}); end
        press(4'b0001);
        tick();
        checks++; if ({wr_en, wr_addr, wr_data} !== 17'h15510) begin errors++; $display("FAIL rw_after: got %h exp 15510", {wr_en, wr_addr, wr_data}); end
        tick();
        pulse_done();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        key_vld = 4'b0000;
        cfg_en  = 1'b1;
        wr_rdy  = 1'b1;
        wr_done = 1'b0;
        test_reset();
        test_basic();
        test_saturate();
        test_multi();
        test_rdy_stall();
        test_cfg_gate();
        test_timeout();
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_cfg_ctrl.md
KEY_CFG_CTRL -- requirements
Module: key_cfg_ctrl

Interface
REQ-001 SHALL have parameter KEY_W, default 4, number of debounced key lines.
REQ-002 SHALL have parameter BRIGHT_ADDR, default 8'h55, camera brightness register address.
REQ-003 SHALL have parameter CONTR_ADDR, default 8'h56, camera contrast register address.
REQ-004 SHALL have parameter STEP, default 8'h10, increment/decrement per key press.
REQ-005 SHALL have parameters BRIGHT_INIT, default 8'h00, and CONTR_INIT, default 8'h40, reset values of the settings.
REQ-006 SHALL have parameter TIMEOUT, default 1_000_000, the maximum number of cycles to wait for wr_done.
REQ-007 SHALL have port clk, input, 1, the single clock of the block.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port key_vld, input, KEY_W, one-cycle press pulses: bit0 brightness+, bit1 brightness-, bit2 contrast+, bit3 contrast-.
REQ-010 SHALL have port cfg_en, input, 1, high when camera init is done and register writes are allowed.
REQ-011 SHALL have ports wr_en, output, 1; wr_addr, output, 8; wr_data, output, 8; these form the register write request.
REQ-012 SHALL have port wr_rdy, input, 1, write master accepts the request.
REQ-013 SHALL have port wr_done, input, 1, one-cycle pulse when the bus write completes.
REQ-014 SHALL have ports bright, output, 8, and contrast, output, 8, giving the current settings.
REQ-015 SHALL have ports busy, output, 1, state not IDLE, and err, output, 1, sticky timeout flag.

Function
REQ-016 SHALL hold a KEY_W-bit pending register; a key_vld bit that is 1 in cycle N SHALL set its pending bit at edge N+1.
REQ-017 SHALL give set priority when a key_vld pulse coincides with the clear of the same pending bit.
REQ-018 SHALL implement the FSM states IDLE, REQ and WAIT.
REQ-019 In IDLE with cfg_en=1 and pending!=0, the FSM SHALL grant the lowest-index pending bit, clear that bit, and apply the update on the same edge.
REQ-020 The update SHALL use saturating 8-bit arithmetic: plus gives min(v+STEP, 8'hFF); minus gives max(v-STEP, 8'h00), computed in 9 bits.
REQ-021 If the saturated result equals the old value, the FSM SHALL clear the pending bit, issue no write, and stay in IDLE.
REQ-022 Otherwise the FSM SHALL update bright or contrast, load wr_addr and wr_data with the new value, and go to REQ; wr_en SHALL be asserted at cycle N+2 after key_vld in cycle N.
REQ-023 In REQ, wr_en, wr_addr and wr_data SHALL be held stable until the cycle in which wr_en=1 and wr_rdy=1, then the FSM SHALL go to WAIT with wr_en=0.
REQ-024 In WAIT, a timeout counter SHALL count cycles; wr_done=1 SHALL return the FSM to IDLE and clear the counter.
REQ-025 If the counter reaches TIMEOUT-1 without wr_done, the FSM SHALL set err=1 and return to IDLE; the setting value SHALL be kept.
REQ-026 A wr_done pulse outside WAIT SHALL be ignored.
REQ-027 If cfg_en=0, pending bits SHALL accumulate with no grant; REQ and WAIT SHALL finish normally when cfg_en falls mid-operation.
REQ-028 Multiple pending bits SHALL be served one transaction at a time, in ascending index order, each re-evaluated at its own IDLE pass.
REQ-029 busy SHALL equal (state!=IDLE) as a registered output.

Reset
REQ-030 While rst_n=0, the block SHALL asynchronously force: state=IDLE, pending=0, counter=0, wr_en=0, wr_addr=0, wr_data=0, bright=BRIGHT_INIT, contrast=CONTR_INIT, busy=0, err=0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no further wr_en; the first grant SHALL come no earlier than 2 cycles after release.

Verification
REQ-032 The bench SHALL drive cfg_en=1, wr_rdy=1, key_vld=4'b0001 for one cycle -> wr_en high 2 cycles later, wr_addr=8'h55, wr_data=8'h10, bright=8'h10; wr_done 5 cycles later -> busy=0.
REQ-033 The bench SHALL press key1 with bright=8'h00 -> no wr_en, pending cleared; then press key0 17 times -> bright saturates at 8'hFF, and the 17th press issues no write.
REQ-034 The bench SHALL send key_vld=4'b1001 in one cycle -> two transactions in order: brightness (8'h55, 8'h10) then contrast (8'h56, 8'h30).
REQ-035 The bench SHALL hold wr_rdy=0 for 10 cycles -> wr_en, wr_addr and wr_data stable throughout; handshake on wr_rdy=1 -> WAIT.
REQ-036 The bench SHALL set TIMEOUT=16 and never pulse wr_done -> err=1 after 16 WAIT cycles, FSM back to IDLE, next pending key still served.
REQ-037 The bench SHALL assert rst_n=0 during WAIT -> all outputs at reset values immediately; a stale wr_done after release is ignored.
